// File: rtl/rvx_mtimer.sv
// rvx_mtimer: machine timer slave. Free-running 64-bit mtime with a 16-bit
// prescaler, a 64-bit mtimecmp and a registered level interrupt. Register
// reads and writes complete with a one-cycle registered response.
module rvx_mtimer #(
   parameter logic [15:0] PRESCALE_RESET = 16'h0000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] address,
   input  logic        rrequest,
   input  logic        wrequest,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrobe,
   output logic [31:0] rdata,
   output logic        rresponse,
   output logic        wresponse,
   output logic [63:0] memory_mapped_timer,
   output logic        irq_timer
);

   localparam logic [2:0] A_MTIME_LO = 3'd0;
   localparam logic [2:0] A_MTIME_HI = 3'd1;
   localparam logic [2:0] A_CMP_LO   = 3'd2;
   localparam logic [2:0] A_CMP_HI   = 3'd3;
   localparam logic [2:0] A_CTRL     = 3'd4;
   localparam logic [2:0] A_PRESCALE = 3'd5;

   logic [63:0] r_mtime;
   logic [63:0] r_mtimecmp;
   logic        r_enable;
   logic [15:0] r_prescale;
   logic [15:0] r_pcnt;
   logic [31:0] r_rdata;
   logic        r_rresponse;
   logic        r_wresponse;
   logic        r_irq;

   logic [2:0]  w_sel;
   logic [31:0] w_bmask;
   logic        w_any_strb;
   logic        w_wr_mlo, w_wr_mhi, w_wr_clo, w_wr_chi, w_wr_ctrl, w_wr_ps;
   logic        w_enable_next;
   logic        w_run;
   logic        w_tick;
   logic [15:0] w_prescale_next;
   logic [15:0] w_pcnt_next;
   logic [63:0] w_mtime_next;
   logic [63:0] w_mtimecmp_next;
   logic [31:0] w_rd_val;
   logic        w_unused_addr;

   // Only the word offset is decoded; the rest of the address is don't-care.
   assign w_unused_addr = ^{address[31:5], address[1:0]};

   assign w_sel      = address[4:2];
   assign w_bmask    = {{8{wstrobe[3]}}, {8{wstrobe[2]}}, {8{wstrobe[1]}}, {8{wstrobe[0]}}};
   assign w_any_strb = |wstrobe;

   assign w_wr_mlo  = wrequest && (w_sel == A_MTIME_LO);
   assign w_wr_mhi  = wrequest && (w_sel == A_MTIME_HI);
   assign w_wr_clo  = wrequest && (w_sel == A_CMP_LO);
   assign w_wr_chi  = wrequest && (w_sel == A_CMP_HI);
   assign w_wr_ctrl = wrequest && (w_sel == A_CTRL);
   assign w_wr_ps   = wrequest && (w_sel == A_PRESCALE);

   // The counter only runs when enable is set both before and after this
   // edge: clearing enable suppresses a coincident tick, while setting it
   // starts counting on the following cycle.
   assign w_enable_next = (w_wr_ctrl && wstrobe[0]) ? wdata[0] : r_enable;
   assign w_run         = r_enable && w_enable_next;
   assign w_tick        = w_run && (r_pcnt == r_prescale);

   assign w_prescale_next = w_wr_ps
      ? ((r_prescale & ~w_bmask[15:0]) | (wdata[15:0] & w_bmask[15:0]))
      : r_prescale;

   // Prescale counter: wraps on a tick, cleared by any effective PRESCALE write.
   always_comb begin
      w_pcnt_next = r_pcnt;
      if (w_wr_ps && (|wstrobe[1:0]))
         w_pcnt_next = 16'd0;
      else if (w_run)
         w_pcnt_next = w_tick ? 16'd0 : r_pcnt + 16'd1;
   end

   // mtime: a software write to either half wins over the tick for all 64 bits.
   always_comb begin
      w_mtime_next = r_mtime;
      if ((w_wr_mlo || w_wr_mhi) && w_any_strb) begin
         if (w_wr_mlo)
            w_mtime_next[31:0]  = (r_mtime[31:0] & ~w_bmask) | (wdata & w_bmask);
         else
            w_mtime_next[63:32] = (r_mtime[63:32] & ~w_bmask) | (wdata & w_bmask);
      end else if (w_tick) begin
         w_mtime_next = r_mtime + 64'd1;
      end
   end

   // mtimecmp byte-merged writes.
   always_comb begin
      w_mtimecmp_next = r_mtimecmp;
      if (w_wr_clo)
         w_mtimecmp_next[31:0]  = (r_mtimecmp[31:0] & ~w_bmask) | (wdata & w_bmask);
      if (w_wr_chi)
         w_mtimecmp_next[63:32] = (r_mtimecmp[63:32] & ~w_bmask) | (wdata & w_bmask);
   end

   // Read mux on pre-update register values.
   always_comb begin
      w_rd_val = 32'd0;
      case (w_sel)
         A_MTIME_LO: w_rd_val = r_mtime[31:0];
         A_MTIME_HI: w_rd_val = r_mtime[63:32];
         A_CMP_LO:   w_rd_val = r_mtimecmp[31:0];
         A_CMP_HI:   w_rd_val = r_mtimecmp[63:32];
         A_CTRL:     w_rd_val = {31'd0, r_enable};
         A_PRESCALE: w_rd_val = {16'd0, r_prescale};
         default:    w_rd_val = 32'd0;
      endcase
   end

   // Register state, responses and interrupt; interrupt compares post-update values.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_mtime     <= 64'd0;
         r_mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
         r_enable    <= 1'b1;
         r_prescale  <= PRESCALE_RESET;
         r_pcnt      <= 16'd0;
         r_rdata     <= 32'd0;
         r_rresponse <= 1'b0;
         r_wresponse <= 1'b0;
         r_irq       <= 1'b0;
      end else begin
         r_mtime     <= w_mtime_next;
         r_mtimecmp  <= w_mtimecmp_next;
         r_enable    <= w_enable_next;
         r_prescale  <= w_prescale_next;
         r_pcnt      <= w_pcnt_next;
         if (rrequest)
            r_rdata  <= w_rd_val;
         r_rresponse <= rrequest;
         r_wresponse <= wrequest;
         r_irq       <= (w_mtime_next >= w_mtimecmp_next);
      end
   end

   assign rdata               = r_rdata;
   assign rresponse           = r_rresponse;
   assign wresponse           = r_wresponse;
   assign memory_mapped_timer = r_mtime;
   assign irq_timer           = r_irq;

endmodule

// File: tb/tb_rvx_mtimer.sv
// tb_rvx_mtimer: directed test-plan steps followed by a randomized phase, all
// checked every cycle against a behavioural model of the timer.
module tb_rvx_mtimer;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] address = 32'd0;
   logic        rrequest = 1'b0;
   logic        wrequest = 1'b0;
   logic [31:0] wdata = 32'd0;
   logic [3:0]  wstrobe = 4'd0;
   logic [31:0] rdata;
   logic        rresponse;
   logic        wresponse;
   logic [63:0] memory_mapped_timer;
   logic        irq_timer;

   int tests = 0;
   int fails = 0;

   rvx_mtimer #(.PRESCALE_RESET(16'h0000)) dut (
      .clock(clock), .reset_n(reset_n), .address(address),
      .rrequest(rrequest), .wrequest(wrequest), .wdata(wdata), .wstrobe(wstrobe),
      .rdata(rdata), .rresponse(rresponse), .wresponse(wresponse),
      .memory_mapped_timer(memory_mapped_timer), .irq_timer(irq_timer)
   );

   always #5 clock = ~clock;

   // Behavioural model state
   logic [63:0] m_time = 64'd0;
   logic [63:0] m_cmp = '1;
   logic        m_en = 1'b1;
   logic [15:0] m_ps = 16'd0;
   logic [15:0] m_pc = 16'd0;
   logic [31:0] m_rdata = 32'd0;
   logic        m_rresp = 1'b0;
   logic        m_wresp = 1'b0;
   logic        m_irq = 1'b0;

   function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] ws);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++)
         if (ws[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] mread(input logic [2:0] s);
      case (s)
         3'd0: return m_time[31:0];
         3'd1: return m_time[63:32];
         3'd2: return m_cmp[31:0];
         3'd3: return m_cmp[63:32];
         3'd4: return {31'd0, m_en};
         3'd5: return {16'd0, m_ps};
         default: return 32'd0;
      endcase
   endfunction

   // One clock edge of the timer as software would describe it.
   task automatic model_step();
      logic [2:0]  s;
      logic        run;
      logic        tick;
      logic [15:0] pc;
      logic [63:0] t;
      logic [31:0] tmp;
      s = address[4:2];
      if (!reset_n) begin
         m_time = 64'd0; m_cmp = '1; m_en = 1'b1; m_ps = 16'd0; m_pc = 16'd0;
         m_rdata = 32'd0; m_rresp = 1'b0; m_wresp = 1'b0; m_irq = 1'b0;
         return;
      end
      if (rrequest) m_rdata = mread(s);
      m_rresp = rrequest;
      m_wresp = wrequest;
      run = m_en;
      if (wrequest && s == 3'd4 && wstrobe[0] && !wdata[0]) run = 1'b0;
      tick = run && (m_pc == m_ps);
      pc = run ? (tick ? 16'd0 : m_pc + 16'd1) : m_pc;
      t = tick ? m_time + 64'd1 : m_time;
      if (wrequest) begin
         case (s)
            3'd0: if (wstrobe != 4'd0) t = {m_time[63:32], bmerge(m_time[31:0], wdata, wstrobe)};
            3'd1: if (wstrobe != 4'd0) t = {bmerge(m_time[63:32], wdata, wstrobe), m_time[31:0]};
            3'd2: m_cmp[31:0]  = bmerge(m_cmp[31:0], wdata, wstrobe);
            3'd3: m_cmp[63:32] = bmerge(m_cmp[63:32], wdata, wstrobe);
            3'd4: if (wstrobe[0]) m_en = wdata[0];
            3'd5: begin
               tmp  = bmerge({16'd0, m_ps}, wdata, wstrobe);
               m_ps = tmp[15:0];
               if (wstrobe[1:0] != 2'd0) pc = 16'd0;
            end
            default: ;
         endcase
      end
      m_time = t;
      m_pc   = pc;
      m_irq  = (m_time >= m_cmp);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge, update the model, then compare all outputs off-edge.
   task automatic step();
      @(posedge clock);
      model_step();
      #1;
      chk("mtime", memory_mapped_timer, m_time);
      chk("irq", 64'(irq_timer), 64'(m_irq));
      chk("rresponse", 64'(rresponse), 64'(m_rresp));
      chk("wresponse", 64'(wresponse), 64'(m_wresp));
      chk("rdata", 64'(rdata), 64'(m_rdata));
   endtask

   task automatic cycle(input logic rr, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
      rrequest = rr; wrequest = wr; address = a; wdata = d; wstrobe = s;
      step();
      rrequest = 1'b0; wrequest = 1'b0; address = 32'd0; wdata = 32'd0; wstrobe = 4'd0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
      cycle(1'b0, 1'b1, a, d, s);
   endtask

   task automatic rd(input logic [31:0] a);
      cycle(1'b1, 1'b0, a, 32'd0, 4'd0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
   endtask

   initial begin
      logic [63:0] t0;
      logic [31:0] a, d;
      logic [3:0]  s;

      // Reset and free-running count
      reset_n = 1'b0;
      idle(2);
      chk("rst_mtime", memory_mapped_timer, 64'd0);
      chk("rst_irq", 64'(irq_timer), 64'd0);
      chk("rst_rresp", 64'(rresponse), 64'd0);
      reset_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         idle(1);
         chk("count_up", memory_mapped_timer, 64'(k));
      end
      rd(32'h0C);
      chk("cmp_hi_reset", 64'(rdata), 64'hFFFF_FFFF);

      // Prescaler: period 4 cycles, then freeze
      wr(32'h14, 32'd3);
      t0 = memory_mapped_timer;
      idle(8);
      chk("prescale3", memory_mapped_timer, t0 + 64'd2);
      wr(32'h10, 32'd0);
      t0 = memory_mapped_timer;
      for (int k = 0; k < 10; k++) begin
         idle(1);
         chk("frozen", memory_mapped_timer, t0);
      end

      // Carry into the high word, then 64-bit wrap
      wr(32'h14, 32'd0);
      wr(32'h00, 32'hFFFF_FFFE);
      wr(32'h04, 32'd0);
      wr(32'h10, 32'd1);
      chk("enable_no_tick", memory_mapped_timer, 64'h0000_0000_FFFF_FFFE);
      idle(2);
      chk("carry", memory_mapped_timer, 64'h0000_0001_0000_0000);
      wr(32'h00, 32'hFFFF_FFFF);
      wr(32'h04, 32'hFFFF_FFFF);
      chk("all_ones", memory_mapped_timer, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("irq_at_max", 64'(irq_timer), 64'd1);
      idle(1);
      chk("wrap", memory_mapped_timer, 64'd0);
      chk("irq_after_wrap", 64'(irq_timer), 64'd0);

      // Compare: irq registered from the post-update compare
      wr(32'h08, 32'd100);
      wr(32'h0C, 32'd0);
      wr(32'h00, 32'd98);
      wr(32'h04, 32'd0);
      chk("mtime98", memory_mapped_timer, 64'd98);
      idle(1);
      chk("irq_at99", 64'(irq_timer), 64'd0);
      idle(1);
      chk("mtime100", memory_mapped_timer, 64'd100);
      chk("irq_at100", 64'(irq_timer), 64'd1);
      wr(32'h08, 32'd1000);
      chk("irq_cleared", 64'(irq_timer), 64'd0);

      // Byte strobes
      wr(32'h08, 32'hFFFF_FFFF);
      wr(32'h08, 32'hAABB_CCDD, 4'b0101);
      rd(32'h08);
      chk("strobe_merge", 64'(rdata), 64'hFFBB_FFDD);

      // Simultaneous read+write returns the old value
      cycle(1'b1, 1'b1, 32'h14, 32'd5, 4'hF);
      chk("rw_old", 64'(rdata), 64'd0);
      chk("rw_both_resp", 64'({rresponse, wresponse}), 64'd3);
      rd(32'h14);
      chk("rw_new", 64'(rdata), 64'd5);

      // Unmapped offsets and ignored address bits
      rd(32'h18);
      chk("unmapped_rd", 64'(rdata), 64'd0);
      chk("unmapped_resp", 64'(rresponse), 64'd1);
      wr(32'h1C, 32'hFFFF_FFFF);
      chk("unmapped_wresp", 64'(wresponse), 64'd1);
      rd(32'h8000_0009);
      chk("alias_cmp_lo", 64'(rdata), 64'hFFBB_FFDD);

      // Reset in the cycle after a read request
      wr(32'h14, 32'd7);
      rd(32'h14);
      chk("pre_reset_resp", 64'(rresponse), 64'd1);
      reset_n = 1'b0;
      idle(1);
      chk("reset_drop_resp", 64'(rresponse), 64'd0);
      chk("reset_mtime", memory_mapped_timer, 64'd0);
      reset_n = 1'b1;
      rd(32'h14);
      chk("reset_prescale", 64'(rdata), 64'd0);

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         reset_n = ($urandom_range(0, 149) != 0);
         a = {$urandom_range(0, 1) == 0 ? 27'd0 : 27'($urandom), 3'($urandom_range(0, 7)), 2'($urandom)};
         case ($urandom_range(0, 3))
            0: d = 32'($urandom_range(0, 7));
            1: d = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
            default: d = $urandom;
         endcase
         // keep the counter enabled most of the time so ticks keep happening
         if (a[4:2] == 3'd4 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
         s = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
         cycle(1'($urandom), 1'($urandom), a, d, s);
      end
      reset_n = 1'b1;
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
